muxn_rr: RTL and testbench
==========================

# muxn_rr

Parametrised N-input, W-bit registered multiplexer with valid/ready handshake on every input and on the output. It is the successor to the team's 4:1 combinational mux. Selection is either fixed, driven by `sel`, or round-robin across requesting channels. It sits between several producer streams and one consumer, with a single-entry output register.

## Interface
- `N`, default 4: number of input channels; must be at least 2.
- `W`, default 8: data width per channel.
- `SW`, default `$clog2(N)`: select/pointer width (derived; do not override).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  N*W  channel i occupies bits [i*W +: W].
- `in_valid`  in  N  per-channel request.
- `in_ready`  out  N  per-channel accept; at most one bit high per cycle.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  SW  channel chosen in fixed mode; ignored in round-robin mode.
- `out_data`  out  W  registered selected data.
- `out_valid`  out  1  output register holds data.
- `out_ready`  in  1  consumer accepts the output.

## Operation
- Transfer on an input channel i happens when `in_valid[i] && in_ready[i]`. Transfer on the output happens when `out_valid && out_ready`.
- `load = !out_valid || out_ready`. The output register can accept new data in the same cycle it drains.
- Grant selection:
  - Fixed mode: grant = `sel` if `sel < N` and `in_valid[sel]`; otherwise there is no grant.
  - `sel >= N` (non-power-of-2 N) means no grant. No X propagation is allowed.
  - Round-robin mode: grant = the first i with `in_valid[i]`, scanning from `ptr` upward modulo N.
- `in_ready[i] = load && (i == grant)`. `in_ready` is combinational from `in_valid`, `mode`, `sel`, `ptr`, `out_valid` and `out_ready`.
- On an input transfer: `out_data <= in_data[grant]` and `out_valid <= 1`.
- On an output transfer with no input transfer: `out_valid <= 0`. `out_data` holds its last value.
- `ptr` handling:
  - In round-robin mode, on an input transfer, `ptr <= (grant + 1) mod N`. The wrap from N-1 goes to 0.
  - `ptr` does not change in fixed mode or on cycles with no transfer.
- A `mode` change takes effect on the same cycle's arbitration; `ptr` is preserved across mode changes.
- Producers must hold `in_valid` and `in_data` until accepted. This is a protocol rule and is not checked by the block.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `ptr = 0`, `in_ready = 0`.
- Reset asserts asynchronously and deasserts synchronously to `clk` (handled externally).
- Latency: an input accepted on cycle k appears on `out_*` at cycle k+1.
- Throughput: one word per cycle while `out_ready` stays high.
- Backpressure: when `out_valid && !out_ready`, all `in_ready` bits are 0 and `out_data` is stable.
- Reset mid-operation: the held word is dropped and `out_valid` falls immediately; after reset, round-robin restarts at channel 0.

## Configuration
- `MUXN_RR_CHAN_ID_EN` defined: adds output port `out_chan` [SW], registered alongside `out_data`. It carries the index of the granted channel and resets to 0.
- `MUXN_RR_CHAN_ID_EN` undefined: the port and its register are absent, and behaviour is otherwise identical.

## Structure
- Package `muxn_pkg`:
  - enum `mux_mode_e` with values `MODE_FIXED = 1'b0` and `MODE_RR = 1'b1`.
  - function `rr_pick(valid, ptr)`, which returns the grant index and a found flag.
- Sub-module `rr_arbiter`: combinational pick from `in_valid` and `ptr`, plus the registered `ptr` update on transfer. It takes `N` as a parameter.
- The top level contains the fixed-mode grant logic, the output register and the handshake logic.

## Test plan
- Reset, then fixed mode with `N=4`, `W=8`, `sel=2`, `in_valid=4'b0100`, `in_data[2]=8'hA5`, `out_ready=1`: `in_ready=4'b0100` on that cycle, then `out_data=8'hA5` and `out_valid=1` on the next cycle.
- Round-robin mode with all four `in_valid` high and `out_ready=1` for 6 cycles: grants go 0,1,2,3,0,1, and `out_data` matches each channel's value with a one-cycle lag.
- Backpressure: hold `out_ready=0` for 3 cycles with `out_valid=1`: `in_ready=0` throughout, and `out_data` and `ptr` are unchanged. Release: one drain-and-load in the same cycle.
- Round-robin with sparse requests: `ptr=3`, `in_valid=4'b0010` → grant 1, then `ptr=2`. Next, `in_valid=4'b0001` → grant 0 (wrap), then `ptr=1`.
- Fixed mode with `N=3` and `sel=3`: no grant and `out_valid` stays 0. Switch `mode` to round-robin: grant comes from the preserved `ptr`.
- Assert `rst_n=0` mid-stream while `out_valid=1`: `out_valid` goes to 0 and `out_data` to 0 without waiting for a clock edge. With `MUXN_RR_CHAN_ID_EN` defined, `out_chan` goes to 0 and matches the grant index in every other scenario.

Source files
------------

// File: rtl/muxn_rr_pkg.sv
// ============================================================================
// Module   : muxn_pkg
// Brief    : Shared types and the round-robin pick helper for muxn_rr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muxn_pkg;

  localparam int unsigned MUXN_MAX_N = 32;
  localparam int unsigned MUXN_IDX_W = 5;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  typedef struct packed {
    logic                  found;
    logic [MUXN_IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MUXN_MAX_N-1:0] valid,
                                       input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned c;
    r = '0;
    for (int unsigned k = 0; k < MUXN_MAX_N; k++) begin
      c = (ptr + k) % n;
      if (k < n && !r.found && valid[c[MUXN_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = c[MUXN_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muxn_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin pick over N requests with a registered pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import muxn_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_valid,
  input  logic          i_advance,
  output logic [SW-1:0] o_grant,
  output logic          o_found
);

  logic [SW-1:0]         r_ptr;
  logic [MUXN_MAX_N-1:0] w_vext;
  rr_pick_t              w_pick;

  always_comb begin
    w_vext         = '0;
    w_vext[N-1:0]  = i_valid;
    w_pick         = rr_pick(w_vext, 32'(r_ptr), N);
  end

  assign o_grant = SW'(w_pick.idx);
  assign o_found = w_pick.found;

  // Pointer moves just past the winner so it has lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant == SW'(N-1)) ? '0 : o_grant + SW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/muxn_rr.sv
// ============================================================================
// Module   : muxn_rr
// Brief    : N:1 registered mux with valid/ready, fixed or round-robin select.
//            Define MUXN_RR_CHAN_ID_EN to add the out_chan index output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muxn_rr
  import muxn_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
`ifdef MUXN_RR_CHAN_ID_EN
  output logic [SW-1:0]  out_chan,
`endif
  input  logic           out_ready
);

  mux_mode_e     w_mode;
  logic          w_load;
  logic          w_xfer;
  logic          w_fix_found;
  logic [SW-1:0] w_fix_grant;
  logic          w_rr_found;
  logic [SW-1:0] w_rr_grant;
  logic          w_found;
  logic [SW-1:0] w_grant;
  logic [W-1:0]  w_sel_data;

  logic [W-1:0]  r_out_data;
  logic          r_out_valid;

  assign w_mode = mux_mode_e'(mode);
  assign w_load = !r_out_valid || out_ready;

  // Loop compare keeps sel >= N (non-power-of-2 N) a clean no-grant.
  always_comb begin
    w_fix_found = 1'b0;
    w_fix_grant = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i) && in_valid[i]) begin
        w_fix_found = 1'b1;
        w_fix_grant = SW'(i);
      end
    end
  end

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (in_valid),
    .i_advance (w_xfer && (w_mode == MODE_RR)),
    .o_grant   (w_rr_grant),
    .o_found   (w_rr_found)
  );

  assign w_found = (w_mode == MODE_RR) ? w_rr_found : w_fix_found;
  assign w_grant = (w_mode == MODE_RR) ? w_rr_grant : w_fix_grant;
  assign w_xfer  = w_load && w_found;

  always_comb begin
    in_ready   = '0;
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SW'(i)) begin
        in_ready[i] = w_xfer;
        w_sel_data  = in_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_data  <= w_sel_data;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

`ifdef MUXN_RR_CHAN_ID_EN
  logic [SW-1:0] r_out_chan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_chan <= '0;
    end else if (w_xfer) begin
      r_out_chan <= w_grant;
    end
  end

  assign out_chan = r_out_chan;
`endif

endmodule

`default_nettype wire

// File: tb/tb_muxn_rr.sv
// ============================================================================
// Module   : tb_muxn_rr
// Brief    : Scoreboard bench for muxn_rr (N=4 main instance, N=3 side instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muxn_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
`ifdef MUXN_RR_CHAN_ID_EN
  logic [SW-1:0]  out_chan;
  logic [1:0]     oc3;
`endif

  logic [23:0] d3;
  logic [2:0]  v3, r3;
  logic        m3, ov3, or3;
  logic [1:0]  s3;
  logic [7:0]  od3;

  always #5 clk = ~clk;

  muxn_rr #(.N(N), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid),
`ifdef MUXN_RR_CHAN_ID_EN
    .out_chan(out_chan),
`endif
    .out_ready(out_ready)
  );

  muxn_rr #(.N(3), .W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3),
    .in_ready(r3), .mode(m3), .sel(s3), .out_data(od3),
    .out_valid(ov3),
`ifdef MUXN_RR_CHAN_ID_EN
    .out_chan(oc3),
`endif
    .out_ready(or3)
  );

  int   checks = 0;
  int   errors = 0;
  int   q_data[$];
  int   q_chan[$];
  logic m_ov;
  int   m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Grant chosen by the stated rules: fixed sel if valid, else first requester from ptr.
  function automatic int model_grant(input logic [N-1:0] v, input logic md,
                                     input logic [SW-1:0] s, input int p);
    if (md == 1'b0) return (int'(s) < N && v[s]) ? int'(s) : -1;
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Drive one cycle of stimulus, predict in_ready and any accepted word.
  task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic md,
                     input logic [SW-1:0] s, input logic ordy, output logic [N-1:0] seen);
    int         g;
    logic       ld;
    logic [N-1:0] er;
    logic [N-1:0] one;
    one      = 4'b0001;
    in_valid = v; in_data = d; mode = md; sel = s; out_ready = ordy;
    @(negedge clk);
    g    = model_grant(v, md, s, m_ptr);
    ld   = !m_ov || ordy;
    er   = (ld && g >= 0) ? (one << g) : '0;
    seen = in_ready;
    check("in_ready", 32'(in_ready), 32'(er));
    if (ld && g >= 0) begin
      q_data.push_back(int'(d[g*W +: W]));
      q_chan.push_back(g);
    end
    @(posedge clk);
    if (ld && g >= 0) begin
      m_ov = 1'b1;
      if (md) m_ptr = (g + 1) % N;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        if (q_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
          check("out_data", 32'(out_data), q_data[0]);
`ifdef MUXN_RR_CHAN_ID_EN
          check("out_chan", 32'(out_chan), q_chan[0]);
`endif
          if (out_ready) begin
            void'(q_data.pop_front());
            void'(q_chan.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   seen;
    logic [N-1:0]   one;
    logic [31:0]    rnd;
    one = 4'b0001;
    rst_n = 1'b0; in_valid = '0; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    v3 = '0; d3 = {8'hC2, 8'hC1, 8'hC0}; m3 = 1'b0; s3 = '0; or3 = 1'b1;
    m_ov = 1'b0; m_ptr = 0;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_n3_out_valid", 32'(ov3), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed select of channel 2.
    d = '0; d[2*W +: W] = 8'hA5;
    cyc(4'b0100, d, 1'b0, 2'd2, 1'b1, seen);
    check("t1_ready", 32'(seen), 32'h4);
    check("t1_out_data", 32'(out_data), 32'hA5);
    check("t1_out_valid", 32'(out_valid), 1);

    // Round-robin with every channel requesting.
    d = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 6; i++) begin
      cyc(4'hF, d, 1'b1, 2'd0, 1'b1, seen);
      check("t2_grant", 32'(seen), 32'(one << (i % 4)));
    end

    // Backpressure, then a single drain-and-load.
    for (int i = 0; i < 3; i++) begin
      cyc(4'hF, d, 1'b1, 2'd0, 1'b0, seen);
      check("t3_bp_ready", 32'(seen), 0);
      check("t3_bp_hold", 32'(out_data), 32'h11);
    end
    cyc(4'hF, d, 1'b1, 2'd0, 1'b1, seen);
    check("t3_release", 32'(seen), 32'h4);
    check("t3_release_data", 32'(out_data), 32'h12);

    // Sparse requests with wrap (ptr is 3 here).
    cyc(4'b0010, d, 1'b1, 2'd0, 1'b1, seen);
    check("t4_sparse1", 32'(seen), 32'h2);
    cyc(4'b0001, d, 1'b1, 2'd0, 1'b1, seen);
    check("t4_wrap0", 32'(seen), 32'h1);
    cyc(4'b0011, d, 1'b1, 2'd0, 1'b1, seen);
    check("t4_ptr1", 32'(seen), 32'h2);
    cyc(4'b0000, d, 1'b1, 2'd0, 1'b1, seen);

    // N=3: out-of-range sel gives no grant; RR resumes from the kept pointer.
    m3 = 1'b1; v3 = 3'b010;
    @(negedge clk); check("n3_rr_first", 32'(r3), 32'h2);
    @(posedge clk); #1;
    m3 = 1'b0; s3 = 2'd3; v3 = 3'b111;
    @(negedge clk); check("n3_sel3_ready_a", 32'(r3), 0);
    @(posedge clk); #1;
    @(negedge clk); check("n3_sel3_ready_b", 32'(r3), 0);
    check("n3_sel3_out_valid", 32'(ov3), 0);
    @(posedge clk); #1;
    m3 = 1'b1;
    @(negedge clk); check("n3_rr_resume", 32'(r3), 32'h4);
    @(posedge clk); #1;
    v3 = '0;
    check("n3_rr_data", 32'(od3), 32'hC2);
    check("n3_rr_valid", 32'(ov3), 1);
`ifdef MUXN_RR_CHAN_ID_EN
    check("n3_rr_chan", 32'(oc3), 2);
`endif

    // Asynchronous reset while holding a word.
    cyc(4'hF, d, 1'b1, 2'd0, 1'b0, seen);
    rst_n = 1'b0; in_valid = '0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 0);
    check("t6_rst_out_data", 32'(out_data), 0);
    check("t6_rst_in_ready", 32'(in_ready), 0);
`ifdef MUXN_RR_CHAN_ID_EN
    check("t6_rst_out_chan", 32'(out_chan), 0);
`endif
    q_data.delete(); q_chan.delete(); m_ov = 1'b0; m_ptr = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(4'hF, d, 1'b1, 2'd0, 1'b1, seen);
    check("t6_rr_restart", 32'(seen), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      d   = {$urandom};
      cyc(rnd[3:0], d, rnd[4], rnd[6:5], rnd[9:8] != 2'b00, seen);
    end
    cyc(4'b0000, d, 1'b0, 2'd0, 1'b1, seen);
    cyc(4'b0000, d, 1'b0, 2'd0, 1'b1, seen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
